// File: rtl/parallel_buffer_reader.sv
// parallel_buffer_reader
//
// Read side of a ping-pong buffer pair. Waits for the buffer it owns
// (readSel) to report FULL, flips the writer over to the other buffer,
// streams DEPTH words downstream under a valid/ready handshake, pops the
// buffer once per accepted word, clears it, and then hands ownership to
// the other buffer. Buffers are always drained in strict alternation.
//
// Parameters
//   DEPTH          words per buffer (2..1024)
// Data width comes from the `inputIndex macro (ports are [`inputIndex:0]).
//
// Ports
//   Clk            clock, rising edge
//   Rst            asynchronous active-high reset
//   FULL0/FULL1    buffer 0/1 holds DEPTH valid words
//   dataIn0/1      head word of buffer 0/1
//   outReady       downstream accepts dataOut this cycle
//   bufferSelect   buffer the writer fills (0 or 1)
//   RD0/RD1        pop strobe to buffer 0/1
//   CLR0/CLR1      clear strobe to buffer 0/1
//   dataOut        word presented downstream
//   dataValid      dataOut is valid
//   busy           block is not idle
//   overrun        (only with PB_READER_OVERRUN_EN) sticky: both buffers
//                  were full while a drain/clear was in progress
//
// Optional feature macro: PB_READER_OVERRUN_EN

`ifndef inputIndex
`define inputIndex 7
`endif

module parallel_buffer_reader #(
  parameter int DEPTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 FULL0,
  input  logic                 FULL1,
  input  logic [`inputIndex:0] dataIn0,
  input  logic [`inputIndex:0] dataIn1,
  input  logic                 outReady,
  output logic                 bufferSelect,
  output logic                 RD0,
  output logic                 RD1,
  output logic                 CLR0,
  output logic                 CLR1,
  output logic [`inputIndex:0] dataOut,
  output logic                 dataValid,
  output logic                 busy
`ifdef PB_READER_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int DATA_W = `inputIndex + 1;
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]       state;
  logic             readSel;
  logic [CNT_W-1:0] wordCount;

  logic             fullSel;
  logic             handshake;

  // Only the FULL flag of the buffer we own can start a drain; the other
  // buffer's flag is ignored so drains stay strictly alternating.
  assign fullSel   = readSel ? FULL1 : FULL0;
  assign handshake = (state == DRAIN) && outReady;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      readSel      <= 1'b0;
      bufferSelect <= 1'b0;
      wordCount    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fullSel) begin
            bufferSelect <= ~readSel;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          // FULL is deliberately not re-checked here: a dropped FULL
          // mid-drain is a writer error and the count simply continues.
          if (handshake) begin
            if (wordCount == LAST_WORD) begin
              wordCount <= '0;
              state     <= CLEAR;
            end else begin
              wordCount <= wordCount + CNT_W'(1);
            end
          end
        end
        CLEAR: begin
          readSel <= ~readSel;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded purely from registered state, so the async reset
  // drives them all to zero immediately.
  always_comb begin
    dataValid = 1'b0;
    dataOut   = '0;
    RD0       = 1'b0;
    RD1       = 1'b0;
    CLR0      = 1'b0;
    CLR1      = 1'b0;
    busy      = (state != IDLE);
    if (state == DRAIN) begin
      dataValid = 1'b1;
      dataOut   = readSel ? dataIn1 : dataIn0;
      RD0       = handshake && !readSel;
      RD1       = handshake && readSel;
    end else if (state == CLEAR) begin
      CLR0 = !readSel;
      CLR1 = readSel;
    end
  end

`ifdef PB_READER_OVERRUN_EN
  // Both buffers full while we are still working means the writer has
  // nowhere to go; latch it until reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      overrun <= 1'b0;
    end else if (FULL0 && FULL1 && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parallel_buffer_reader.sv
`ifndef inputIndex
`define inputIndex 7
`endif

module tb_parallel_buffer_reader;

  localparam int DEPTH = 4;
  localparam int DW    = `inputIndex + 1;

  logic          Clk;
  logic          Rst;
  logic          FULL0, FULL1;
  logic [DW-1:0] dataIn0, dataIn1;
  logic          outReady;
  logic          bufferSelect, RD0, RD1, CLR0, CLR1;
  logic [DW-1:0] dataOut;
  logic          dataValid, busy;
`ifdef PB_READER_OVERRUN_EN
  logic          overrun;
`endif

  parallel_buffer_reader #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .FULL0(FULL0), .FULL1(FULL1),
    .dataIn0(dataIn0), .dataIn1(dataIn1), .outReady(outReady),
    .bufferSelect(bufferSelect), .RD0(RD0), .RD1(RD1),
    .CLR0(CLR0), .CLR1(CLR1), .dataOut(dataOut),
    .dataValid(dataValid), .busy(busy)
`ifdef PB_READER_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {dataValid, RD0, RD1, CLR0, CLR1, bufferSelect, busy};
  endfunction

  // ---------------- behavioural reference model ----------------
  // Buffers are plain arrays with a head index; the reader is described
  // by "words still to deliver" and "clear pending" plus which buffer it
  // owns and where the writer has been pointed.
  logic [DW-1:0] bufdata [2][DEPTH+1];
  int  head   [2];
  bit  full_b [2];
  bit  ordy_b;
  int  m_rs, m_left, m_bsel;
  bit  m_clr, m_ovr;

  task automatic model_init();
    m_rs = 0; m_left = 0; m_clr = 0; m_bsel = 0; m_ovr = 0;
  endtask

  task automatic fill(input int x);
    for (int k = 0; k < DEPTH; k++) bufdata[x][k] = DW'($urandom);
    bufdata[x][DEPTH] = '0;
    head[x]   = 0;
    full_b[x] = 1;
  endtask

  task automatic check_model();
    bit e_vld;
    logic [6:0] e_ctl;
    logic [DW-1:0] e_dout;
    e_vld  = (m_left > 0);
    e_dout = e_vld ? bufdata[m_rs][DEPTH - m_left] : '0;
    e_ctl  = {e_vld,
              e_vld && ordy_b && (m_rs == 0),
              e_vld && ordy_b && (m_rs == 1),
              m_clr && (m_rs == 0),
              m_clr && (m_rs == 1),
              m_bsel[0],
              e_vld || m_clr};
    chk("model_ctl", 64'(ctl_now()), 64'(e_ctl));
    chk("model_dout", 64'(dataOut), 64'(e_dout));
`ifdef PB_READER_OVERRUN_EN
    chk("model_overrun", 64'(overrun), 64'(m_ovr));
`endif
  endtask

  task automatic eng_cycle();
    bit sf0, sf1, so, bpre;
    FULL0 = full_b[0]; FULL1 = full_b[1]; outReady = ordy_b;
    dataIn0 = bufdata[0][head[0]];
    dataIn1 = bufdata[1][head[1]];
    @(negedge Clk);
    check_model();
    sf0 = full_b[0]; sf1 = full_b[1]; so = ordy_b;
    @(posedge Clk); #1;
    bpre = (m_left > 0) || m_clr;
    if (sf0 && sf1 && bpre) m_ovr = 1;
    if (m_clr) begin
      full_b[m_rs] = 0;
      m_clr = 0;
      m_rs  = 1 - m_rs;
    end else if (m_left > 0) begin
      if (so) begin
        head[m_rs]++;
        m_left--;
        if (m_left == 0) m_clr = 1;
      end
    end else if ((m_rs == 0) ? sf0 : sf1) begin
      m_left = DEPTH;
      m_bsel = 1 - m_rs;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, 64'(ctl_now()), 64'd0);
    chk({nm, "_dout"}, 64'(dataOut), 64'd0);
`ifdef PB_READER_OVERRUN_EN
    chk({nm, "_ovr"}, 64'(overrun), 64'd0);
`endif
  endtask

  // Assert reset away from a clock edge, check outputs immediately,
  // release at posedge+1 so the next stimulus lines up with later tasks.
  task automatic do_reset();
    full_b[0] = 0; full_b[1] = 0; ordy_b = 0;
    FULL0 = 0; FULL1 = 0; outReady = 0;
    Rst = 1'b1;
    #1;
    check_zero("reset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_init();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          f0, f1, rdy;
    logic [DW-1:0] d0, d1;
    logic [6:0]    ctl;   // {vld, rd0, rd1, clr0, clr1, bsel, busy}
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [DW-1:0] a0, a1, a2, a3, b0;
    a0 = DW'('hA0); a1 = DW'('hA1); a2 = DW'('hA2); a3 = DW'('hA3); b0 = DW'('hB0);
    //           f0 f1 rdy d0  d1  vld rd0 rd1 cl0 cl1 bs busy  dout
    tbl[0]  = '{1, 0, 1, a0, 0,  7'b0_0_0_0_0_0_0, 0};
    tbl[1]  = '{1, 0, 1, a0, 0,  7'b1_1_0_0_0_1_1, a0};
    tbl[2]  = '{1, 0, 0, a1, 0,  7'b1_0_0_0_0_1_1, a1};
    tbl[3]  = '{1, 0, 0, a1, 0,  7'b1_0_0_0_0_1_1, a1};
    tbl[4]  = '{1, 0, 1, a1, 0,  7'b1_1_0_0_0_1_1, a1};
    tbl[5]  = '{1, 0, 1, a2, 0,  7'b1_1_0_0_0_1_1, a2};
    tbl[6]  = '{1, 0, 1, a3, 0,  7'b1_1_0_0_0_1_1, a3};
    tbl[7]  = '{0, 0, 1, 0,  0,  7'b0_0_0_1_0_1_1, 0};
    tbl[8]  = '{0, 0, 1, 0,  0,  7'b0_0_0_0_0_1_0, 0};
    tbl[9]  = '{1, 0, 1, a0, 0,  7'b0_0_0_0_0_1_0, 0};
    tbl[10] = '{1, 0, 1, a0, 0,  7'b0_0_0_0_0_1_0, 0};
    tbl[11] = '{0, 1, 0, 0,  b0, 7'b0_0_0_0_0_1_0, 0};
    tbl[12] = '{0, 1, 0, 0,  b0, 7'b1_0_0_0_0_0_1, b0};

    Rst = 1'b0; FULL0 = 0; FULL1 = 0; outReady = 0; dataIn0 = '0; dataIn1 = '0;
    for (int x = 0; x < 2; x++) begin
      for (int k = 0; k <= DEPTH; k++) bufdata[x][k] = '0;
      head[x] = 0; full_b[x] = 0;
    end
    ordy_b = 0;
    model_init();
    #3;
    do_reset();

    // single drain with backpressure, then out-of-turn FULL0 ignored
    for (int i = 0; i < 13; i++) begin
      FULL0 = tbl[i].f0; FULL1 = tbl[i].f1; outReady = tbl[i].rdy;
      dataIn0 = tbl[i].d0; dataIn1 = tbl[i].d1;
      @(negedge Clk);
      chk($sformatf("tbl%0d_ctl", i), 64'(ctl_now()), 64'(tbl[i].ctl));
      chk($sformatf("tbl%0d_dout", i), 64'(dataOut), 64'(tbl[i].dout));
      @(posedge Clk); #1;
    end

    // out-of-order full: buffer 1 full first must be ignored
    do_reset();
    fill(1);
    ordy_b = 1;
    for (int i = 0; i < 10; i++) eng_cycle();
    fill(0);
    for (int i = 0; i < 14; i++) eng_cycle();

    // alternation with both buffers full, then a further drain
    do_reset();
    fill(0); fill(1);
    ordy_b = 1;
    for (int i = 0; i < 12; i++) eng_cycle();
    fill(0);
    for (int i = 0; i < 8; i++) eng_cycle();

    // reset after the second handshake: partial drain abandoned, no clear
    do_reset();
    fill(0);
    ordy_b = 1;
    for (int i = 0; i < 3; i++) eng_cycle();
    #2;
    Rst = 1'b1;
    #1;
    check_zero("midreset_async");
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check_zero("midreset_hold");
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_init();
    full_b[1] = 0;
    fill(0);
    for (int i = 0; i < 8; i++) eng_cycle();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ordy_b = ($urandom_range(0, 3) != 0);
      for (int x = 0; x < 2; x++)
        if (!full_b[x] && ($urandom_range(0, 5) == 0)) fill(x);
      eng_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
